// File: rtl/pipe_stage_reg.sv
// ---------------------------------------------------------------------------
// pipe_stage_reg
//
// Purpose:
//   A generic, flushable pipeline stage register. It carries a WIDTH-bit
//   payload between two pipeline stages using a ready/valid handshake.
//   A one-entry skid buffer lets in_ready be a registered signal. Stalls
//   therefore do not need a combinational enable chain that runs back
//   through the whole pipeline.
//
// Optional feature:
//   PIPE_STAGE_FLUSH_CLEAR_EN
//     Defined   : a flush also loads the main and skid registers with
//                 FLUSH_VALUE. The bubble that follows a flush then reads
//                 as a harmless NOP bundle.
//     Undefined : a flush only empties the stage. The payload registers
//                 keep their old contents, so consumers must qualify the
//                 payload with out_valid.
//
// Parameters:
//   WIDTH        payload width in bits (>= 1)
//   FLUSH_VALUE  payload loaded on flush (only with PIPE_STAGE_FLUSH_CLEAR_EN)
//   CNT_W        width of the saturating stall-cycle counter (>= 1)
//
// Ports:
//   CLK        in   rising-edge clock
//   nRST       in   asynchronous, active-low reset
//   flush      in   synchronous flush; discards every held entry
//   in_valid   in   upstream presents a payload
//   in_ready   out  stage can accept a payload (registered)
//   in_data    in   upstream payload
//   out_valid  out  out_data holds a valid payload (registered)
//   out_ready  in   downstream accepts the head payload this cycle
//   out_data   out  head payload (the main register)
//   stall_cnt  out  saturating count of cycles with out_valid=1, out_ready=0
// ---------------------------------------------------------------------------
module pipe_stage_reg #(
   parameter int               WIDTH       = 32,
   parameter logic [WIDTH-1:0] FLUSH_VALUE = '0,
   parameter int               CNT_W       = 16
) (
   input  logic             CLK,
   input  logic             nRST,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [CNT_W-1:0] stall_cnt
);

   // The occupancy of the stage. EMPTY holds no entry. BUSY holds one entry
   // in the main register. FULL holds the main entry plus one entry in the
   // skid register.
   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      BUSY  = 2'd1,
      FULL  = 2'd2
   } state_t;

   state_t           state;
   state_t           next_state;
   logic [WIDTH-1:0] main_q;
   logic [WIDTH-1:0] main_next;
   logic [WIDTH-1:0] skid_q;
   logic [WIDTH-1:0] skid_next;
   logic             accept;
   logic             drain;
   logic             stalled;

   // Both handshake outputs are decoded from the state register only.
   // No input reaches them combinationally. This is what lets stalls stop
   // at this stage instead of rippling upstream in the same cycle.
   assign out_valid = (state != EMPTY);
   assign in_ready  = (state != FULL);
   assign out_data  = main_q;

   // A transfer on either side happens only when both halves of the
   // handshake are high at the rising edge.
   assign accept  = in_valid & in_ready;
   assign drain   = out_valid & out_ready;
   assign stalled = out_valid & ~out_ready;

`ifndef PIPE_STAGE_FLUSH_CLEAR_EN
   // When flush does not clear the payload, FLUSH_VALUE has no function.
   // This named tie-off keeps the parameter visibly consumed.
   logic [WIDTH-1:0] unused_flush_value;
   assign unused_flush_value = FLUSH_VALUE;
`endif

   // State and payload registers. Reset returns the stage to EMPTY and
   // zeroes both payload registers, so out_data is never X after reset,
   // even before the first transfer.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state  <= EMPTY;
         main_q <= '0;
         skid_q <= '0;
      end else begin
         state  <= next_state;
         main_q <= main_next;
         skid_q <= skid_next;
      end
   end

   // Next-state and payload-load logic. Every register holds by default.
   // The transition cases below are the only places that load data.
   // Flush comes first and overrides everything. A same-cycle accept is
   // dropped. A same-cycle drain is seen downstream, but the stage does
   // not advance, because the stage empties anyway.
   always_comb begin
      next_state = state;
      main_next  = main_q;
      skid_next  = skid_q;

      if (flush) begin
         next_state = EMPTY;
`ifdef PIPE_STAGE_FLUSH_CLEAR_EN
         main_next  = FLUSH_VALUE;
         skid_next  = FLUSH_VALUE;
`endif
      end else begin
         case (state)
            EMPTY: begin
               // Nothing can drain from an empty stage. An accept goes
               // straight into the main register, which gives the
               // one-cycle latency.
               if (accept) begin
                  next_state = BUSY;
                  main_next  = in_data;
               end
            end

            BUSY: begin
               if (accept && !drain) begin
                  // Downstream stalled while a new payload arrived.
                  // Park the new payload in the skid register. in_ready
                  // drops next cycle.
                  next_state = FULL;
                  skid_next  = in_data;
               end else if (!accept && drain) begin
                  next_state = EMPTY;
               end else if (accept && drain) begin
                  // Streaming at full rate: the head leaves and the new
                  // payload replaces it.
                  main_next = in_data;
               end
            end

            FULL: begin
               // in_ready is low here, so no accept is possible. A drain
               // promotes the skid entry to the head, which keeps
               // strict FIFO order.
               if (drain) begin
                  next_state = BUSY;
                  main_next  = skid_q;
               end
            end

            default: begin
               next_state = EMPTY;
            end
         endcase
      end
   end

   // Stall-cycle counter. It counts every cycle in which the head is valid
   // but downstream refuses it. It sticks at all-ones instead of wrapping,
   // so a long stall never reads as a short one. Only reset clears it; a
   // flush leaves it alone, so stall history survives pipeline redirects.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         stall_cnt <= '0;
      end else if (stalled && (stall_cnt != {CNT_W{1'b1}})) begin
         stall_cnt <= stall_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// ---------------------------------------------------------------------------
// tb_pipe_stage_reg
//
// Self-checking bench for pipe_stage_reg. The reference model is a FIFO
// queue with a capacity of two entries, plus a saturating stall counter.
// A held-data register tracks what out_data shows while the queue is
// empty.
// Build with +define+PIPE_STAGE_FLUSH_CLEAR_EN to exercise the flush-clear
// variant; the model follows the same macro.
// ---------------------------------------------------------------------------
module tb_pipe_stage_reg;

   localparam int               WIDTH   = 32;
   localparam int               CNT_W   = 3;
   localparam logic [WIDTH-1:0] FLUSH_V = 32'h0000_0013;
   localparam int               CNT_MAX = (1 << CNT_W) - 1;

   logic             CLK;
   logic             nRST;
   logic             flush;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_data;
   logic [CNT_W-1:0] stall_cnt;

   int errorCount;
   int checkCount;

   // Reference model state.
   logic [WIDTH-1:0] modelQ[$];
   logic [WIDTH-1:0] modelShown;
   int               modelCnt;

   pipe_stage_reg #(
      .WIDTH      (WIDTH),
      .FLUSH_VALUE(FLUSH_V),
      .CNT_W      (CNT_W)
   ) dut (
      .CLK      (CLK),
      .nRST     (nRST),
      .flush    (flush),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_data  (in_data),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_data (out_data),
      .stall_cnt(stall_cnt)
   );

   // 10-time-unit clock with the rising edges at 5, 15, 25, ...
   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Single comparison point. It counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
      end
   endtask

   // Compare every DUT output against the model's current view.
   task automatic compareAll(input string tag);
      checkOutput({tag, ".out_valid"}, {31'd0, out_valid}, {31'd0, modelQ.size() > 0});
      checkOutput({tag, ".in_ready"},  {31'd0, in_ready},  {31'd0, modelQ.size() < 2});
      checkOutput({tag, ".out_data"},  out_data, modelShown);
      checkOutput({tag, ".stall_cnt"}, {{(32-CNT_W){1'b0}}, stall_cnt}, modelCnt);
   endtask

   // Drive one cycle of inputs, advance the model by the rules for that
   // edge, then check the outputs just after the edge.
   // Returns 1 if the payload was accepted upstream.
   task automatic applyStimulus(input logic v, input logic [WIDTH-1:0] d,
                                input logic r, input logic f, input string tag,
                                output logic accepted);
      logic acc;
      logic drn;
      in_valid  = v;
      in_data   = d;
      out_ready = r;
      flush     = f;
      acc = v && (modelQ.size() < 2);
      drn = (modelQ.size() > 0) && r;
      if ((modelQ.size() > 0) && !r && (modelCnt < CNT_MAX)) modelCnt++;
      if (f) begin
         modelQ.delete();
`ifdef PIPE_STAGE_FLUSH_CLEAR_EN
         modelShown = FLUSH_V;
`endif
      end else begin
         if (drn) void'(modelQ.pop_front());
         if (acc) modelQ.push_back(d);
         if (modelQ.size() > 0) modelShown = modelQ[0];
      end
      accepted = acc;
      @(posedge CLK);
      #1;
      compareAll(tag);
   endtask

   // Assert reset asynchronously between clock edges and check that it
   // takes effect immediately. Then release reset, also away from an edge.
   task automatic asyncReset(input string tag);
      nRST = 1'b0;
      #1;
      modelQ.delete();
      modelShown = '0;
      modelCnt   = 0;
      compareAll(tag);
      #2;
      nRST = 1'b1;
   endtask

   initial begin
      logic acc;
      logic curV;
      logic [WIDTH-1:0] curD;
      errorCount = 0;
      checkCount = 0;
      modelShown = '0;
      modelCnt   = 0;
      nRST      = 1'b0;
      flush     = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b0;

      // Reset state
      repeat (2) @(posedge CLK);
      #1;
      compareAll("reset");
      #2;
      nRST = 1'b1;

      // Single transfer, then the stage returns to empty.
      applyStimulus(1'b1, 32'hA5A5_A5A5, 1'b1, 1'b0, "single", acc);
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, "single_drain", acc);
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, "single_idle", acc);

      // Back-pressure and skid: the value 3 is held upstream until accepted.
      applyStimulus(1'b1, 32'h1, 1'b0, 1'b0, "bp1", acc);
      applyStimulus(1'b1, 32'h2, 1'b0, 1'b0, "bp2", acc);
      applyStimulus(1'b1, 32'h3, 1'b0, 1'b0, "bp3_held", acc);
      checkOutput("bp3_not_accepted", {31'd0, acc}, 32'd0);
      applyStimulus(1'b1, 32'h3, 1'b1, 1'b0, "bp_rel1", acc);
      applyStimulus(1'b1, 32'h3, 1'b1, 1'b0, "bp_rel2", acc);
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, "bp_rel3", acc);
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, "bp_empty", acc);

      // Full throughput
      for (int i = 0; i < 16; i++)
         applyStimulus(1'b1, 32'h10 + i, 1'b1, 1'b0, "stream", acc);
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, "stream_tail", acc);

      // Flush while FULL with a same-cycle accept attempt.
      applyStimulus(1'b1, 32'h55, 1'b0, 1'b0, "fl_fill1", acc);
      applyStimulus(1'b1, 32'h66, 1'b0, 1'b0, "fl_fill2", acc);
      applyStimulus(1'b1, 32'hDEAD, 1'b0, 1'b1, "flush_full", acc);
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, "post_flush", acc);

      // Counter saturation starts from a clean reset. A flush then leaves
      // the counter unchanged.
      asyncReset("sat_reset");
      applyStimulus(1'b1, 32'h77, 1'b0, 1'b0, "sat_load", acc);
      for (int i = 0; i < 10; i++)
         applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, "sat_hold", acc);
      checkOutput("sat_value", {{(32-CNT_W){1'b0}}, stall_cnt}, CNT_MAX);
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, "sat_flush", acc);
      checkOutput("sat_after_flush", {{(32-CNT_W){1'b0}}, stall_cnt}, CNT_MAX);

      // Asynchronous reset in the middle of a stream while FULL.
      applyStimulus(1'b1, 32'h88, 1'b0, 1'b0, "ar_fill1", acc);
      applyStimulus(1'b1, 32'h99, 1'b0, 1'b0, "ar_fill2", acc);
      asyncReset("async_reset");
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, "ar_after", acc);

      // Randomised traffic. Upstream holds its payload until accepted.
      curV = 1'b0;
      curD = '0;
      for (int i = 0; i < 400; i++) begin
         logic r;
         logic f;
         if (!curV || acc) begin
            curV = ($urandom_range(0, 3) != 0);
            curD = $urandom;
         end
         r = ($urandom_range(0, 2) != 0);
         f = ($urandom_range(0, 24) == 0);
         applyStimulus(curV, curD, r, f, "random", acc);
         // Upstream counts a flushed handshake as done, so the payload is
         // not offered again.
         if (f && curV && (acc || in_ready)) acc = 1'b1;
      end

      $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
      $finish;
   end

   // Hard timeout so the bench always ends on its own.
   initial begin
      #200000;
      $display("[TB] FAIL timeout: simulation exceeded its time budget");
      $fatal(1, "timeout");
   end

endmodule
